sqrt_request_arbiter: RTL and testbench

- Shares one iterative unsigned square-root unit between N_REQ requesters, e.g. the integer ALU issue port and the FP unit.
- Sequences the unit: round-robin request selection, one-cycle start pulse, wait for completion, then returns root/remainder tagged with the requester index through a valid/ready response port.
- Sits in the execution stage between the issue logic and the sqrt datapath.
- Exactly one operation is in flight at a time.

---
 rtl/sqrt_ctrl_pkg.sv | 29 ++
 rtl/rr_arbiter.sv | 32 +++
 rtl/sqrt_request_arbiter.sv | 164 ++++++++++++++++
 tb/tb_sqrt_request_arbiter.sv | 517 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sqrt_ctrl_pkg.sv
// Shared types for the square-root request arbiter: FSM state encoding,
// iteration count helper and the registered response record.
package sqrt_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StRespond
  } state_e;

  // Number of root bits produced, one per iteration of the sqrt unit.
  function automatic int unsigned iterations(input int unsigned data_width);
    return data_width / 2;
  endfunction

  // The response record is sized for the widest supported configuration
  // (DATA_WIDTH up to 64, N_REQ up to 8); narrower builds zero-extend into it.
  localparam int unsigned MaxDataWidth = 64;
  localparam int unsigned MaxIdW       = 3;
  localparam int unsigned MaxRootW     = iterations(MaxDataWidth);

  typedef struct packed {
    logic [MaxIdW-1:0]   id;
    logic [MaxRootW-1:0] root;
    logic [MaxRootW:0]   remainder;
  } rsp_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: grants the first set request found when
// searching upward from ptr_i, wrapping modulo N_REQ.
module rr_arbiter #(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [ID_W-1:0]  ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]  idx_o,
  output logic             valid_o
);

  logic [ID_W-1:0] w_cand [N_REQ];

  // Walk candidates in priority order starting at the pointer.
  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    w_cand  = '{default: '0};
    for (int unsigned k = 0; k < N_REQ; k++) begin
      w_cand[k] = ID_W'((32'(ptr_i) + k) % N_REQ);
      if (!valid_o && req_i[w_cand[k]]) begin
        valid_o          = 1'b1;
        idx_o            = w_cand[k];
        gnt_o[w_cand[k]] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sqrt_request_arbiter.sv
// Shares one iterative sqrt unit between N_REQ requesters: round-robin
// accept, one-cycle start pulse, wait for completion, tagged response.
// Optional macro SQRT_TRIVIAL_BYPASS_EN answers radicands below 4 directly.
import sqrt_ctrl_pkg::*;

module sqrt_request_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned N_REQ      = 2,
  parameter int unsigned ID_W       = $clog2(N_REQ)
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic                          clk_en_i,
  input  logic                          flush_i,
  input  logic [N_REQ-1:0]              req_valid_i,
  input  logic [N_REQ*DATA_WIDTH-1:0]   req_radicand_i,
  output logic [N_REQ-1:0]              req_ready_o,
  output logic                          rsp_valid_o,
  input  logic                          rsp_ready_i,
  output logic [ID_W-1:0]               rsp_id_o,
  output logic [DATA_WIDTH/2-1:0]       rsp_root_o,
  output logic [DATA_WIDTH/2:0]         rsp_remainder_o,
  output logic                          sqrt_valid_o,
  output logic [DATA_WIDTH-1:0]         sqrt_radicand_o,
  output logic                          sqrt_clk_en_o,
  input  logic                          sqrt_valid_i,
  input  logic                          sqrt_idle_i,
  input  logic [DATA_WIDTH/2-1:0]       sqrt_root_i,
  input  logic [DATA_WIDTH/2:0]         sqrt_remainder_i,
  output logic                          busy_o
);

  localparam int unsigned RootW = iterations(DATA_WIDTH);

  state_e                r_state, w_state_d;
  logic [ID_W-1:0]       r_ptr, w_ptr_d, w_next_ptr;
  logic [DATA_WIDTH-1:0] r_radicand, w_radicand_d;
  rsp_t                  r_rsp, w_rsp_d;
  logic                  r_discard, w_discard_d;

  logic [N_REQ-1:0]      w_gnt;
  logic [ID_W-1:0]       w_idx;
  logic                  w_any;
  logic [DATA_WIDTH-1:0] w_sel_rad;
  logic                  w_trivial;
  logic                  w_accept;
  logic                  w_byp_root;
  logic [1:0]            w_byp_rem;
  logic                  w_unused_rsp;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_rr_arbiter (
    .req_i   (req_valid_i),
    .ptr_i   (r_ptr),
    .gnt_o   (w_gnt),
    .idx_o   (w_idx),
    .valid_o (w_any)
  );

  assign w_sel_rad  = req_radicand_i[w_idx*DATA_WIDTH +: DATA_WIDTH];
  assign w_next_ptr = (w_idx == ID_W'(N_REQ - 1)) ? '0 : w_idx + 1'b1;
  assign w_byp_root = |w_sel_rad[1:0];
  assign w_byp_rem  = w_sel_rad[1:0] - {1'b0, w_byp_root};

`ifdef SQRT_TRIVIAL_BYPASS_EN
  assign w_trivial = ~|w_sel_rad[DATA_WIDTH-1:2];
`else
  assign w_trivial = 1'b0;
`endif

  // Bypass-eligible grants need no free sqrt unit; a stall holds off acceptance.
  assign w_accept = clk_en_i && !flush_i && (r_state == StIdle) && w_any &&
                    (sqrt_idle_i || w_trivial);

  // State register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= StIdle;
    end else if (clk_en_i) begin
      r_state <= w_state_d;
    end
  end

  // Next-state logic; flush wins over a same-cycle completion or accept.
  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle:    if (w_accept) w_state_d = w_trivial ? StRespond : StIssue;
      StIssue:   w_state_d = flush_i ? StIdle : StWait;
      StWait:    if (sqrt_valid_i) w_state_d = (r_discard || flush_i) ? StIdle : StRespond;
      StRespond: if (flush_i || rsp_ready_i) w_state_d = StIdle;
      default:   w_state_d = StIdle;
    endcase
  end

  // Datapath registers: pointer, latched operand, response record, discard flag.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_ptr      <= '0;
      r_radicand <= '0;
      r_rsp      <= '0;
      r_discard  <= 1'b0;
    end else if (clk_en_i) begin
      r_ptr      <= w_ptr_d;
      r_radicand <= w_radicand_d;
      r_rsp      <= w_rsp_d;
      r_discard  <= w_discard_d;
    end
  end

  // Datapath next values.
  always_comb begin
    w_ptr_d      = r_ptr;
    w_radicand_d = r_radicand;
    w_rsp_d      = r_rsp;
    w_discard_d  = r_discard;
    case (r_state)
      StIdle: begin
        w_discard_d = 1'b0;
        if (w_accept) begin
          w_ptr_d      = w_next_ptr;
          w_radicand_d = w_sel_rad;
          w_rsp_d.id   = MaxIdW'(w_idx);
          if (w_trivial) begin
            w_rsp_d.root      = MaxRootW'(w_byp_root);
            w_rsp_d.remainder = (MaxRootW + 1)'(w_byp_rem);
          end
        end
      end
      StWait: begin
        if (sqrt_valid_i) begin
          w_discard_d = 1'b0;
          if (!(r_discard || flush_i)) begin
            w_rsp_d.root      = MaxRootW'(sqrt_root_i);
            w_rsp_d.remainder = (MaxRootW + 1)'(sqrt_remainder_i);
          end
        end else if (flush_i) begin
          // The unit cannot be aborted, so remember to drop its result.
          w_discard_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Outputs decoded from the current state.
  always_comb begin
    req_ready_o  = w_accept ? w_gnt : '0;
    sqrt_valid_o = clk_en_i && (r_state == StIssue) && !flush_i;
    rsp_valid_o  = (r_state == StRespond) && !flush_i;
    busy_o       = (r_state != StIdle);
  end

  assign sqrt_clk_en_o   = clk_en_i;
  assign sqrt_radicand_o = r_radicand;
  assign rsp_id_o        = r_rsp.id[ID_W-1:0];
  assign rsp_root_o      = r_rsp.root[RootW-1:0];
  assign rsp_remainder_o = r_rsp.remainder[RootW:0];
  // Upper bits of the record are constant zero in narrower builds.
  assign w_unused_rsp    = ^r_rsp;

endmodule

// File: tb/tb_sqrt_request_arbiter.sv
// Directed bench for sqrt_request_arbiter with a behavioural iterative sqrt
// unit model (fixed latency, honours sqrt_clk_en_o).
module tb_sqrt_request_arbiter;

  localparam int unsigned DW  = 32;
  localparam int unsigned NR  = 2;
  localparam int unsigned IW  = 1;
  localparam int unsigned RW  = DW / 2;
  localparam int unsigned LAT = RW + 2;

  logic            clk_i = 1'b0;
  logic            rst_n_i = 1'b0;
  logic            clk_en_i = 1'b1;
  logic            flush_i = 1'b0;
  logic [NR-1:0]   req_valid_i = '0;
  logic [NR*DW-1:0] req_radicand_i = '0;
  logic [NR-1:0]   req_ready_o;
  logic            rsp_valid_o;
  logic            rsp_ready_i = 1'b0;
  logic [IW-1:0]   rsp_id_o;
  logic [RW-1:0]   rsp_root_o;
  logic [RW:0]     rsp_remainder_o;
  logic            sqrt_valid_o;
  logic [DW-1:0]   sqrt_radicand_o;
  logic            sqrt_clk_en_o;
  logic            sqrt_valid_i = 1'b0;
  logic            sqrt_idle_i;
  logic [RW-1:0]   sqrt_root_i = '0;
  logic [RW:0]     sqrt_remainder_i = '0;
  logic            busy_o;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  sqrt_request_arbiter #(
    .DATA_WIDTH (DW),
    .N_REQ      (NR),
    .ID_W       (IW)
  ) dut (
    .clk_i            (clk_i),
    .rst_n_i          (rst_n_i),
    .clk_en_i         (clk_en_i),
    .flush_i          (flush_i),
    .req_valid_i      (req_valid_i),
    .req_radicand_i   (req_radicand_i),
    .req_ready_o      (req_ready_o),
    .rsp_valid_o      (rsp_valid_o),
    .rsp_ready_i      (rsp_ready_i),
    .rsp_id_o         (rsp_id_o),
    .rsp_root_o       (rsp_root_o),
    .rsp_remainder_o  (rsp_remainder_o),
    .sqrt_valid_o     (sqrt_valid_o),
    .sqrt_radicand_o  (sqrt_radicand_o),
    .sqrt_clk_en_o    (sqrt_clk_en_o),
    .sqrt_valid_i     (sqrt_valid_i),
    .sqrt_idle_i      (sqrt_idle_i),
    .sqrt_root_i      (sqrt_root_i),
    .sqrt_remainder_i (sqrt_remainder_i),
    .busy_o           (busy_o)
  );

  // ---------------- sqrt unit model ----------------
  function automatic logic [RW-1:0] isqrt(input logic [DW-1:0] x);
    logic [DW-1:0] r;
    r = '0;
    while ((r + 1) * (r + 1) <= x) r = r + 1;
    return r[RW-1:0];
  endfunction

  function automatic logic [RW:0] isrem(input logic [DW-1:0] x);
    logic [DW-1:0] r;
    logic [DW-1:0] d;
    r = {{(DW-RW){1'b0}}, isqrt(x)};
    d = x - r * r;
    return d[RW:0];
  endfunction

  logic          m_busy = 1'b0;
  int            m_cnt  = 0;
  logic [RW-1:0] m_root = '0;
  logic [RW:0]   m_rem  = '0;

  assign sqrt_idle_i = !m_busy;

  always @(posedge clk_i) begin
    if (sqrt_clk_en_o) begin
      sqrt_valid_i <= 1'b0;
      if (m_busy) begin
        if (m_cnt == 1) begin
          sqrt_valid_i     <= 1'b1;
          sqrt_root_i      <= m_root;
          sqrt_remainder_i <= m_rem;
          m_busy           <= 1'b0;
        end else begin
          m_cnt <= m_cnt - 1;
        end
      end else if (sqrt_valid_o) begin
        m_busy <= 1'b1;
        m_cnt  <= LAT;
        m_root <= isqrt(sqrt_radicand_o);
        m_rem  <= isrem(sqrt_radicand_o);
      end
    end
  end

  // ---------------- helpers (no checks inside) ----------------
  task automatic cyc();
    @(negedge clk_i);
    #1;
  endtask

  task automatic wait_grant(input int max, output logic [NR-1:0] g, output bit ok);
    ok = 1'b0;
    g  = '0;
    #1;
    for (int i = 0; i < max; i++) begin
      if (req_ready_o != '0) begin
        g  = req_ready_o;
        ok = 1'b1;
        break;
      end
      cyc();
    end
  endtask

  task automatic wait_rsp(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (rsp_valid_o) begin
        ok = 1'b1;
        break;
      end
      cyc();
    end
  endtask

  task automatic wait_done(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (sqrt_valid_i) begin
        ok = 1'b1;
        break;
      end
      cyc();
    end
  endtask

  task automatic accept_rsp();
    rsp_ready_i = 1'b1;
    cyc();
    rsp_ready_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_n_i = 1'b0;
    cyc();
    cyc();
    rst_n_i = 1'b1;
    cyc();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n_i = 1'b0;
    cyc();
    total++;
    if (busy_o !== 1'b0 || rsp_valid_o !== 1'b0 || sqrt_valid_o !== 1'b0 ||
        req_ready_o !== 2'b00) begin
      bad++;
      $display("FAIL reset_ctrl: busy=%b rsp_valid=%b sqrt_valid=%b ready=%b, want 0 0 0 00",
               busy_o, rsp_valid_o, sqrt_valid_o, req_ready_o);
    end
    total++;
    if (rsp_root_o !== '0 || rsp_remainder_o !== '0 || rsp_id_o !== '0) begin
      bad++;
      $display("FAIL reset_data: root=%0d rem=%0d id=%0d, want 0 0 0",
               rsp_root_o, rsp_remainder_o, rsp_id_o);
    end
    rst_n_i = 1'b1;
    cyc();
  endtask

  task automatic test_single();
    bit ok;
    req_valid_i = 2'b01;
    req_radicand_i[DW-1:0] = 32'd144;
    #1;
    total++;
    if (req_ready_o !== 2'b01) begin
      bad++;
      $display("FAIL single_grant: ready=%b want 01", req_ready_o);
    end
    cyc();
    req_valid_i = 2'b00;
    #1;
    total++;
    if (sqrt_valid_o !== 1'b1 || sqrt_radicand_o !== 32'd144) begin
      bad++;
      $display("FAIL single_start: sqrt_valid=%b rad=%0d want 1 144", sqrt_valid_o,
               sqrt_radicand_o);
    end
    cyc();
    total++;
    if (sqrt_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL single_one_pulse: sqrt_valid=%b want 0", sqrt_valid_o);
    end
    wait_done(60, ok);
    total++;
    if (!ok || rsp_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL single_done: seen=%0d rsp_valid=%b want 1 0", ok, rsp_valid_o);
    end
    cyc();
    total++;
    if (rsp_valid_o !== 1'b1 || rsp_root_o !== 16'd12 || rsp_remainder_o !== 17'd0 ||
        rsp_id_o !== 1'b0) begin
      bad++;
      $display("FAIL single_rsp: valid=%b root=%0d rem=%0d id=%0d want 1 12 0 0",
               rsp_valid_o, rsp_root_o, rsp_remainder_o, rsp_id_o);
    end
    accept_rsp();
    total++;
    if (busy_o !== 1'b0 || rsp_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL single_idle: busy=%b rsp_valid=%b want 0 0", busy_o, rsp_valid_o);
    end
  endtask

  task automatic test_contention();
    logic [NR-1:0] exp_g [3] = '{2'b01, 2'b10, 2'b01};
    logic [RW-1:0] exp_r [3] = '{16'd3, 16'd4, 16'd3};
    logic [IW-1:0] exp_i [3] = '{1'b0, 1'b1, 1'b0};
    logic [NR-1:0] g;
    bit ok;
    do_reset();
    req_radicand_i = {32'd17, 32'd10};
    req_valid_i    = 2'b11;
    for (int k = 0; k < 3; k++) begin
      wait_grant(20, g, ok);
      total++;
      if (!ok || g !== exp_g[k]) begin
        bad++;
        $display("FAIL contention_grant%0d: seen=%0d grant=%b want %b", k, ok, g, exp_g[k]);
      end
      cyc();
      if (k == 2) req_valid_i = 2'b00;
      wait_rsp(80, ok);
      total++;
      if (!ok || rsp_root_o !== exp_r[k] || rsp_remainder_o !== 17'd1 ||
          rsp_id_o !== exp_i[k]) begin
        bad++;
        $display("FAIL contention_rsp%0d: seen=%0d root=%0d rem=%0d id=%0d want %0d 1 %0d",
                 k, ok, rsp_root_o, rsp_remainder_o, rsp_id_o, exp_r[k], exp_i[k]);
      end
      accept_rsp();
    end
  endtask

  task automatic test_backpressure();
    logic [NR-1:0] g;
    bit ok;
    req_radicand_i = {32'd5, 32'd99};
    req_valid_i    = 2'b01;
    wait_grant(20, g, ok);
    total++;
    if (!ok || g !== 2'b01) begin
      bad++;
      $display("FAIL bp_grant: seen=%0d grant=%b want 01", ok, g);
    end
    cyc();
    req_valid_i = 2'b00;
    wait_rsp(80, ok);
    req_valid_i = 2'b10;
    for (int i = 0; i < 5; i++) begin
      #1;
      total++;
      if (!ok || rsp_valid_o !== 1'b1 || rsp_root_o !== 16'd9 || rsp_remainder_o !== 17'd18 ||
          rsp_id_o !== 1'b0 || req_ready_o !== 2'b00) begin
        bad++;
        $display("FAIL bp_hold%0d: valid=%b root=%0d rem=%0d id=%0d ready=%b want 1 9 18 0 00",
                 i, rsp_valid_o, rsp_root_o, rsp_remainder_o, rsp_id_o, req_ready_o);
      end
      cyc();
    end
    accept_rsp();
    #1;
    total++;
    if (req_ready_o !== 2'b10) begin
      bad++;
      $display("FAIL bp_next_grant: ready=%b want 10", req_ready_o);
    end
    cyc();
    req_valid_i = 2'b00;
    wait_rsp(80, ok);
    total++;
    if (!ok || rsp_root_o !== 16'd2 || rsp_remainder_o !== 17'd1 || rsp_id_o !== 1'b1) begin
      bad++;
      $display("FAIL bp_second_rsp: seen=%0d root=%0d rem=%0d id=%0d want 2 1 1",
               ok, rsp_root_o, rsp_remainder_o, rsp_id_o);
    end
    accept_rsp();
  endtask

  task automatic test_flush_wait();
    logic [NR-1:0] g;
    bit ok;
    bit seen_rsp;
    req_radicand_i = {32'd0, 32'd1000};
    req_valid_i    = 2'b01;
    wait_grant(20, g, ok);
    cyc();
    req_valid_i = 2'b00;
    cyc();
    cyc();
    flush_i = 1'b1;
    cyc();
    flush_i = 1'b0;
    total++;
    if (busy_o !== 1'b1) begin
      bad++;
      $display("FAIL flush_still_busy: busy=%b want 1", busy_o);
    end
    seen_rsp = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (rsp_valid_o) seen_rsp = 1'b1;
      if (sqrt_valid_i) begin
        ok = 1'b1;
        break;
      end
      cyc();
    end
    cyc();
    if (rsp_valid_o) seen_rsp = 1'b1;
    cyc();
    if (rsp_valid_o) seen_rsp = 1'b1;
    total++;
    if (!ok || seen_rsp || busy_o !== 1'b0) begin
      bad++;
      $display("FAIL flush_discard: done=%0d rsp_seen=%0d busy=%b want 1 0 0",
               ok, seen_rsp, busy_o);
    end
    req_radicand_i = {32'd0, 32'd49};
    req_valid_i    = 2'b01;
    wait_grant(20, g, ok);
    cyc();
    req_valid_i = 2'b00;
    wait_rsp(80, ok);
    total++;
    if (!ok || rsp_root_o !== 16'd7 || rsp_remainder_o !== 17'd0) begin
      bad++;
      $display("FAIL flush_next_rsp: seen=%0d root=%0d rem=%0d want 7 0",
               ok, rsp_root_o, rsp_remainder_o);
    end
    accept_rsp();
  endtask

  task automatic test_stall_reset();
    logic [NR-1:0] g;
    bit ok;
    req_radicand_i = {32'd0, 32'd200};
    req_valid_i    = 2'b01;
    wait_grant(20, g, ok);
    cyc();
    req_valid_i = 2'b00;
    cyc();
    cyc();
    cyc();
    clk_en_i = 1'b0;
    #1;
    total++;
    if (sqrt_clk_en_o !== 1'b0) begin
      bad++;
      $display("FAIL stall_clk_en: sqrt_clk_en=%b want 0", sqrt_clk_en_o);
    end
    for (int i = 0; i < 4; i++) begin
      cyc();
      total++;
      if (busy_o !== 1'b1 || rsp_valid_o !== 1'b0 || sqrt_valid_o !== 1'b0) begin
        bad++;
        $display("FAIL stall_wait%0d: busy=%b rsp_valid=%b sqrt_valid=%b want 1 0 0",
                 i, busy_o, rsp_valid_o, sqrt_valid_o);
      end
    end
    clk_en_i = 1'b1;
    wait_rsp(80, ok);
    total++;
    if (!ok || rsp_root_o !== 16'd14 || rsp_remainder_o !== 17'd4) begin
      bad++;
      $display("FAIL stall_rsp: seen=%0d root=%0d rem=%0d want 14 4",
               ok, rsp_root_o, rsp_remainder_o);
    end
    // Consumer ready while stalled must not retire the response.
    clk_en_i    = 1'b0;
    rsp_ready_i = 1'b1;
    cyc();
    cyc();
    total++;
    if (rsp_valid_o !== 1'b1 || rsp_root_o !== 16'd14) begin
      bad++;
      $display("FAIL stall_respond: valid=%b root=%0d want 1 14", rsp_valid_o, rsp_root_o);
    end
    clk_en_i = 1'b1;
    cyc();
    rsp_ready_i = 1'b0;
    total++;
    if (busy_o !== 1'b0) begin
      bad++;
      $display("FAIL stall_release: busy=%b want 0", busy_o);
    end

    req_radicand_i = {32'd0, 32'd64};
    req_valid_i    = 2'b01;
    wait_grant(20, g, ok);
    cyc();
    req_valid_i = 2'b00;
    cyc();
    cyc();
    rst_n_i = 1'b0;
    #1;
    total++;
    if (busy_o !== 1'b0 || rsp_valid_o !== 1'b0 || sqrt_valid_o !== 1'b0 ||
        rsp_root_o !== '0 || rsp_remainder_o !== '0) begin
      bad++;
      $display("FAIL async_reset: busy=%b rsp_valid=%b sqrt_valid=%b root=%0d rem=%0d want 0",
               busy_o, rsp_valid_o, sqrt_valid_o, rsp_root_o, rsp_remainder_o);
    end
    cyc();
    rst_n_i = 1'b1;
    req_radicand_i = {32'd0, 32'd49};
    req_valid_i    = 2'b01;
    #1;
    total++;
    if (req_ready_o !== 2'b00) begin
      bad++;
      $display("FAIL reset_unit_busy: ready=%b want 00", req_ready_o);
    end
    wait_grant(60, g, ok);
    total++;
    if (!ok || g !== 2'b01 || sqrt_idle_i !== 1'b1) begin
      bad++;
      $display("FAIL reset_first_grant: seen=%0d grant=%b idle=%b want 01 1", ok, g,
               sqrt_idle_i);
    end
    cyc();
    req_valid_i = 2'b00;
    wait_rsp(80, ok);
    total++;
    if (!ok || rsp_root_o !== 16'd7 || rsp_id_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_next_rsp: seen=%0d root=%0d id=%0d want 7 0", ok, rsp_root_o,
               rsp_id_o);
    end
    accept_rsp();
  endtask

  task automatic test_bypass();
    logic [NR-1:0] g;
    bit ok;
    req_radicand_i = {32'd0, 32'd3};
    req_valid_i    = 2'b01;
    wait_grant(20, g, ok);
    total++;
    if (!ok || g !== 2'b01) begin
      bad++;
      $display("FAIL bypass_grant: seen=%0d grant=%b want 01", ok, g);
    end
    cyc();
    req_valid_i = 2'b00;
`ifdef SQRT_TRIVIAL_BYPASS_EN
    total++;
    if (sqrt_valid_o !== 1'b0 || rsp_valid_o !== 1'b1 || rsp_root_o !== 16'd1 ||
        rsp_remainder_o !== 17'd2) begin
      bad++;
      $display("FAIL bypass_rsp: sqrt_valid=%b valid=%b root=%0d rem=%0d want 0 1 1 2",
               sqrt_valid_o, rsp_valid_o, rsp_root_o, rsp_remainder_o);
    end
`else
    total++;
    if (sqrt_valid_o !== 1'b1 || rsp_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL nobypass_start: sqrt_valid=%b rsp_valid=%b want 1 0", sqrt_valid_o,
               rsp_valid_o);
    end
    wait_rsp(80, ok);
    total++;
    if (!ok || rsp_root_o !== 16'd1 || rsp_remainder_o !== 17'd2) begin
      bad++;
      $display("FAIL nobypass_rsp: seen=%0d root=%0d rem=%0d want 1 2", ok, rsp_root_o,
               rsp_remainder_o);
    end
`endif
    accept_rsp();
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_flush_wait();
    test_stall_reset();
    test_bypass();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
